// File: rtl/mem_msg_pkg.sv
// rtl/mem_msg_pkg.sv - shared memory message types for the memory server models
package mem_msg_pkg;

    localparam int MEM_OPAQ_BITS = 8;

    typedef enum logic {
        MEM_OP_READ  = 1'b0,
        MEM_OP_WRITE = 1'b1
    } mem_op_t;

    typedef struct packed {
        mem_op_t                  op;
        logic [MEM_OPAQ_BITS-1:0] opaque;
        logic [31:0]              addr;
        logic [31:0]              data;
    } mem_resp_t;

endpackage

// File: rtl/mem_server_resp_fifo.sv
// rtl/mem_server_resp_fifo.sv - in-order response buffer with a registered output stage
module mem_server_resp_fifo
    import mem_msg_pkg::*;
#(
    parameter int p_width = 8,
    parameter int p_depth = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [p_width-1:0] i_push_data,
    input  logic               i_pop,
    input  logic               i_hold,
    output logic               o_val,
    output logic [p_width-1:0] o_data
);

    localparam int AW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int CW = $clog2(p_depth + 1);

    logic [p_width-1:0] r_buf [p_depth];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_out_val;
    logic [p_width-1:0] r_out_data;

    logic w_buf_empty;
    logic w_out_free;
    logic w_load;
    logic w_from_buf;
    logic w_buf_push;

    // The output register refills whenever it is empty or being consumed, unless held;
    // a push that finds the buffer empty bypasses straight into the output register.
    always_comb begin
        w_buf_empty = (r_count == '0);
        w_out_free  = !r_out_val || i_pop;
        w_load      = w_out_free && !i_hold && (!w_buf_empty || i_push);
        w_from_buf  = w_load && !w_buf_empty;
        w_buf_push  = i_push && !(w_load && w_buf_empty);
    end

    // Buffer storage needs no reset; validity lives in r_count.
    always_ff @(posedge clk) begin
        if (w_buf_push) begin
            r_buf[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and the presented output entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_val  <= 1'b0;
            r_out_data <= '0;
        end else begin
            if (w_buf_push) begin
                r_wr_ptr <= (r_wr_ptr == AW'(p_depth - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_from_buf) begin
                r_rd_ptr <= (r_rd_ptr == AW'(p_depth - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_buf_push, w_from_buf})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_load) begin
                r_out_val  <= 1'b1;
                r_out_data <= w_from_buf ? r_buf[r_rd_ptr] : i_push_data;
            end else if (w_out_free) begin
                r_out_val  <= 1'b0;
            end
        end
    end

    assign o_val  = r_out_val;
    assign o_data = r_out_data;

endmodule

// File: rtl/mem_server_latency.sv
// rtl/mem_server_latency.sv - fixed-latency memory server; MEM_SERVER_RAND_STALL_EN adds LFSR response stalls
module mem_server_latency
    import mem_msg_pkg::*;
#(
    parameter int          p_opaq_bits  = 8,
    parameter int          p_num_words  = 1024,
    parameter int          p_latency    = 2,
    parameter int          p_resp_depth = 4,
    parameter logic [15:0] p_seed       = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic                   req_op,
    input  logic [p_opaq_bits-1:0] req_opaque,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_data,
    input  logic [3:0]             req_strb,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic                   resp_op,
    output logic [p_opaq_bits-1:0] resp_opaque,
    output logic [31:0]            resp_addr,
    output logic [31:0]            resp_data
);

    localparam int AW = $clog2(p_num_words);
    localparam int CW = $clog2(p_resp_depth + 1);
    localparam int PW = 1 + p_opaq_bits + 64;

    logic [31:0]   r_mem [p_num_words];
    logic [CW-1:0] r_credits;
    logic          r_req_rdy;

    logic          w_req_fire;
    logic          w_resp_fire;
    logic          w_is_write;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd_data;
    logic [PW-1:0] w_in_data;
    logic [CW-1:0] w_credits_next;
    logic          w_push;
    logic [PW-1:0] w_push_data;
    logic          w_hold;
    logic [PW-1:0] w_fifo_data;
    logic          w_unused_addr;

    assign w_idx         = req_addr[2 +: AW];
    assign w_unused_addr = ^{req_addr[31:2+AW], req_addr[1:0]};
    assign w_rd_data     = r_mem[w_idx];
    assign w_is_write    = (mem_op_t'(req_op) == MEM_OP_WRITE);
    assign w_req_fire    = req_val && r_req_rdy;
    assign w_resp_fire   = resp_val && resp_rdy;
    assign w_in_data     = {req_op, req_opaque, req_addr, (w_is_write ? 32'h0 : w_rd_data)};

    // Next credit count: one per request in flight or buffered.
    always_comb begin
        w_credits_next = r_credits;
        case ({w_req_fire, w_resp_fire})
            2'b10:   w_credits_next = r_credits + 1'b1;
            2'b01:   w_credits_next = r_credits - 1'b1;
            default: w_credits_next = r_credits;
        endcase
    end

    // Byte-masked write in the accept cycle; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_req_fire && w_is_write) begin
            for (int b = 0; b < 4; b++) begin
                if (req_strb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= req_data[8*b +: 8];
                end
            end
        end
    end

    // Credits and a registered ready so req_rdy has no path from request/response inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits <= '0;
            r_req_rdy <= 1'b0;
        end else begin
            r_credits <= w_credits_next;
            r_req_rdy <= (w_credits_next < CW'(p_resp_depth));
        end
    end

    // The FIFO output register is the final latency stage, so the pipe holds p_latency-1 stages.
    generate
        if (p_latency > 1) begin : g_pipe
            logic          r_pipe_val  [p_latency-1];
            logic [PW-1:0] r_pipe_data [p_latency-1];

            // Shift accepted requests toward the response buffer.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < p_latency - 1; k++) begin
                        r_pipe_val[k]  <= 1'b0;
                        r_pipe_data[k] <= '0;
                    end
                end else begin
                    r_pipe_val[0]  <= w_req_fire;
                    r_pipe_data[0] <= w_in_data;
                    for (int k = 1; k < p_latency - 1; k++) begin
                        r_pipe_val[k]  <= r_pipe_val[k-1];
                        r_pipe_data[k] <= r_pipe_data[k-1];
                    end
                end
            end

            assign w_push      = r_pipe_val[p_latency-2];
            assign w_push_data = r_pipe_data[p_latency-2];
        end else begin : g_no_pipe
            assign w_push      = w_req_fire;
            assign w_push_data = w_in_data;
        end
    endgenerate

`ifdef MEM_SERVER_RAND_STALL_EN
    logic [15:0] r_lfsr;

    // Free-running Galois LFSR; bit 0 blocks presenting a new response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= p_seed;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign w_hold = r_lfsr[0];
`else
    assign w_hold = 1'b0;
`endif

    mem_server_resp_fifo #(
        .p_width (PW),
        .p_depth (p_resp_depth)
    ) u_resp_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (resp_rdy),
        .i_hold      (w_hold),
        .o_val       (resp_val),
        .o_data      (w_fifo_data)
    );

    assign req_rdy = r_req_rdy;
    assign {resp_op, resp_opaque, resp_addr, resp_data} = w_fifo_data;

endmodule

// File: tb/tb_mem_server_latency.sv
// tb/tb_mem_server_latency.sv - directed self-checking bench for mem_server_latency
module tb_mem_server_latency;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_val = 1'b0;
    logic        req_rdy;
    logic        req_op = 1'b0;
    logic [7:0]  req_opaque = 8'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  req_strb = 4'h0;
    logic        resp_val;
    logic        resp_rdy = 1'b1;
    logic        resp_op;
    logic [7:0]  resp_opaque;
    logic [31:0] resp_addr;
    logic [31:0] resp_data;

    int n_pass  = 0;
    int n_total = 0;

    mem_server_latency #(
        .p_opaq_bits  (8),
        .p_num_words  (1024),
        .p_latency    (2),
        .p_resp_depth (4),
        .p_seed       (16'hACE1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_op      (req_op),
        .req_opaque  (req_opaque),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_strb    (req_strb),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_op     (resp_op),
        .resp_opaque (resp_opaque),
        .resp_addr   (resp_addr),
        .resp_data   (resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the request fired.
    task automatic send(input logic op, input logic [7:0] opq, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        int k;
        req_val = 1'b1; req_op = op; req_opaque = opq;
        req_addr = a; req_data = d; req_strb = s;
        k = 0;
        while (!req_rdy && k < 50) begin @(negedge clk); k++; end
        chk("req_rdy_wait", {31'h0, req_rdy}, 32'h1);
        @(negedge clk);
        req_val = 1'b0;
    endtask

    task automatic wait_resp();
        int k;
        k = 0;
        while (!resp_val && k < 40) begin @(negedge clk); k++; end
        chk("resp_timeout", {31'h0, resp_val}, 32'h1);
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        send(1'b0, 8'h5A, a, 32'h0, 4'h0);
        wait_resp();
        chk(tag, resp_data, exp);
        chk("rd_opaque", {24'h0, resp_opaque}, 32'h5A);
        chk("rd_addr", resp_addr, a);
        idle(4);
    endtask

    initial begin
        int acc;
        int cnt;
        logic [7:0] snap;

        // reset state
        idle(2);
        chk("rst_req_rdy", {31'h0, req_rdy}, 32'h0);
        chk("rst_resp_val", {31'h0, resp_val}, 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_resp_opaque", {24'h0, resp_opaque}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_rdy", {31'h0, req_rdy}, 32'h1);

        // full write, read back with exact latency
        send(1'b1, 8'h01, 32'h100, 32'hDEADBEEF, 4'hF);
        wait_resp();
        chk("wr_resp_op", {31'h0, resp_op}, 32'h1);
        chk("wr_resp_data", resp_data, 32'h0);
        idle(4);
        send(1'b0, 8'h02, 32'h100, 32'h0, 4'h0);
`ifndef MEM_SERVER_RAND_STALL_EN
        chk("lat_early", {31'h0, resp_val}, 32'h0);
        @(negedge clk);
        chk("lat_exact", {31'h0, resp_val}, 32'h1);
`endif
        wait_resp();
        chk("rd_deadbeef", resp_data, 32'hDEADBEEF);
        chk("rd_opaque2", {24'h0, resp_opaque}, 32'h02);
        chk("rd_op", {31'h0, resp_op}, 32'h0);
        idle(4);

        // byte strobes
        send(1'b1, 8'h03, 32'h40, 32'h11223344, 4'hF);
        send(1'b1, 8'h04, 32'h40, 32'hAABBCCDD, 4'b0101);
        idle(6);
        read_check("rd_strb", 32'h40, 32'h11BB33DD);

        // back-to-back ordering, one response per cycle
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    int k;
                    req_val = 1'b1; req_op = 1'b0; req_opaque = 8'(i); req_addr = 32'(i * 4);
                    k = 0;
                    while (!req_rdy && k < 50) begin @(negedge clk); k++; end
                    @(negedge clk);
                end
                req_val = 1'b0;
            end
            begin
                int got;
                int last;
                got = 0; last = -1;
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if (resp_val) begin
                        chk("ord_opaque", {24'h0, resp_opaque}, 32'(got));
`ifndef MEM_SERVER_RAND_STALL_EN
                        if (got > 0) chk("ord_gap", 32'(c - last), 32'h1);
`endif
                        last = c;
                        got++;
                    end
                end
                chk("ord_count", 32'(got), 32'h8);
            end
        join

        // credit limit with resp_rdy low
        resp_rdy = 1'b0;
        req_val = 1'b1; req_op = 1'b0; req_addr = 32'h0; req_opaque = 8'hC0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            if (req_rdy) acc++;
            @(negedge clk);
        end
        chk("credit_accepts", 32'(acc), 32'h4);
        chk("credit_rdy_low", {31'h0, req_rdy}, 32'h0);
        wait_resp();
        snap = resp_opaque;
        @(negedge clk);
        chk("hold_val", {31'h0, resp_val}, 32'h1);
        chk("hold_opaque", {24'h0, resp_opaque}, {24'h0, snap});
        for (int r = 0; r < 2; r++) begin
            wait_resp();
            resp_rdy = 1'b1;
            @(negedge clk);
            resp_rdy = 1'b0;
            acc = 0;
            for (int c = 0; c < 5; c++) begin
                if (req_rdy) acc++;
                @(negedge clk);
            end
            chk("drain_one_accept", 32'(acc), 32'h1);
        end
        req_val = 1'b0;
        resp_rdy = 1'b1;
        idle(20);

        // address wrap
        send(1'b1, 8'h07, 32'h1000, 32'h5, 4'hF);
        idle(4);
        read_check("rd_wrap", 32'h0, 32'h5);

        // reset with requests in flight
        resp_rdy = 1'b0;
        send(1'b0, 8'h10, 32'h0, 32'h0, 4'h0);
        send(1'b0, 8'h11, 32'h4, 32'h0, 4'h0);
        send(1'b0, 8'h12, 32'h8, 32'h0, 4'h0);
`ifndef MEM_SERVER_RAND_STALL_EN
        chk("pre_rst_val", {31'h0, resp_val}, 32'h1);
`endif
        #2 rst = 1'b1;
        #1;
        chk("async_rst_val", {31'h0, resp_val}, 32'h0);
        chk("async_rst_rdy", {31'h0, req_rdy}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        resp_rdy = 1'b1;
        @(negedge clk);
        chk("rst_rel_rdy", {31'h0, req_rdy}, 32'h1);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (resp_val) cnt++;
            @(negedge clk);
        end
        chk("no_stale", 32'(cnt), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
